// File: rtl/sequential_right_shifter.sv
// sequential_right_shifter
//   Multi-cycle logical/arithmetic right shifter for the ALU datapath.
//   It shifts one bit position per clock, is controlled by a start/busy/done
//   handshake, and reports the last bit shifted out of bit 0 for the flags logic.
//
// Ports
//   clk    : rising-edge clock
//   rst    : asynchronous, active-high reset
//   start  : launch request, sampled only while idle
//   a      : operand, captured on the accepting edge
//   shamt  : shift amount, clamped to WIDTH, captured on the accepting edge
//   arith  : 1 = sign fill, 0 = zero fill, captured on the accepting edge
//   y      : result, updated only when done rises and held afterwards
//   cout   : last bit shifted out (0 when the effective amount is 0)
//   busy   : high while a shift is in progress
//   done   : single-cycle completion pulse (busy is already low in that cycle)
module sequential_right_shifter #(
  parameter int WIDTH = 4,
  localparam int SW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [SW-1:0] MAX_AMT = SW'(WIDTH);

  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic             arith_q, arith_d;
  logic             icout_q, icout_d;
  logic [WIDTH-1:0] y_q,     y_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    arith_d = arith_q;
    icout_d = icout_q;
    y_d     = y_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = a;
          // Amounts beyond WIDTH shift out every bit; WIDTH steps give the same result.
          cnt_d   = (shamt > MAX_AMT) ? MAX_AMT : shamt;
          arith_d = arith;
          icout_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          work_d  = {arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
          icout_d = work_q[0];
          cnt_d   = cnt_q - SW'(1);
        end else begin
          y_d     = work_q;
          cout_d  = icout_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      arith_q <= 1'b0;
      icout_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      arith_q <= arith_d;
      icout_q <= icout_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign y    = y_q;
  assign cout = cout_q;
  assign done = done_q;
  assign busy = (state_q == SHIFT);

endmodule

// File: doc/sequential_right_shifter.md
# sequential_right_shifter

Multi-cycle right shifter for the ALU datapath, complementing the combinational left logical shifter. It performs a logical or arithmetic right shift of a WIDTH-bit operand by a variable amount, one bit position per clock. A start/busy/done handshake lets the ALU controller launch a shift and wait for completion. It sits beside the left shifter as the ALU's right-shift resource and also reports the last bit shifted out, for the flags logic.

## Interface

- WIDTH, 4, operand and result width in bits (WIDTH >= 2).
- SW, $clog2(WIDTH)+1, local parameter; width of the shift amount.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch request; sampled only in IDLE.
- a  input  WIDTH  operand; captured on the accepting edge.
- shamt  input  SW  shift amount; captured on the accepting edge.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured on the accepting edge.
- y  output  WIDTH  result; updated only when done rises, then held.
- cout  output  1  last bit shifted out of bit 0; 0 when the effective amount is 0.
- busy  output  1  high while a shift is in progress.
- done  output  1  single-cycle completion pulse.

## Operation

- States: IDLE, SHIFT.
- IDLE with start=1:
  - load the working register with a;
  - load the counter with min(shamt, WIDTH);
  - latch arith, clear the internal cout;
  - go to SHIFT.
- IDLE with start=0: hold all state.
- SHIFT with counter != 0, on each edge:
  - working register <= {fill, reg[WIDTH-1:1]}, where fill = arith ? reg[WIDTH-1] : 0;
  - internal cout <= reg[0];
  - counter decrements by 1.
- SHIFT with counter == 0, on the edge:
  - y <= working register, cout <= internal cout;
  - done <= 1;
  - go to IDLE.
- Clamping: shamt > WIDTH is treated as WIDTH.
  - Logical result is 0.
  - Arithmetic result is all copies of a[WIDTH-1].
  - cout is a[WIDTH-1].
- busy = (state == SHIFT), decoded from the state register.
- done is registered. It is high for exactly one cycle, and busy is already 0 in that cycle.
- start while busy is ignored. The in-flight operation and its operands are unaffected.
- start in the same cycle that done is high is accepted, since the block is in IDLE.
- Inputs a, shamt and arith may change freely after the accepting edge.

## Timing

- Reset values: y = 0, cout = 0, busy = 0, done = 0, state IDLE, counter 0, working register 0.
- Latency with effective amount k = min(shamt, WIDTH):
  - edge E0 accepts start;
  - edges E1..Ek shift;
  - edge Ek+1 registers y, cout and done.
  - done is therefore high in the cycle after Ek+1, i.e. k+1 edges after E0.
- Throughput: back-to-back operations with start held high issue every k+2 edges.
- busy is high from after E0 until after Ek+1.
- Reset asserted mid-operation:
  - aborts immediately and asynchronously;
  - no done is produced;
  - y and cout return to 0;
  - after reset deasserts, the block waits in IDLE for a new start.
- y and cout are stable between done pulses. No glitches on these outputs outside the done edge.

## Test plan

All scenarios use WIDTH=4 (SW=3).

- Logical shift by 1: a=4'b1000, shamt=1, arith=0, start for 1 cycle -> busy high for 2 cycles; done pulses 2 edges after acceptance; y=4'b0100, cout=0.
- Logical multi-bit shift: a=4'b1011, shamt=2 -> y=4'b0010, cout=1 after 3 edges. Then a=4'b1111, shamt=3 -> y=4'b0001, cout=1.
- Arithmetic shift:
  - a=4'b1010, shamt=1, arith=1 -> y=4'b1101, cout=0.
  - a=4'b0110, shamt=2, arith=1 -> y=4'b0001, cout=1.
- Zero amount and clamping:
  - shamt=0, a=4'b1001 -> y=4'b1001, cout=0, done 1 edge after acceptance.
  - shamt=7, a=4'b1010, arith=1 -> clamped to 4; y=4'b1111, cout=1, done 5 edges after acceptance.
  - shamt=7, arith=0 -> y=4'b0000.
- Handshake:
  - start pulsed again, with different a, while busy -> ignored; the first result is delivered unchanged.
  - start held high continuously -> a new operation is accepted in each done cycle, with no lost or duplicated done pulses.
- Reset mid-shift: a=4'b1111, shamt=4, assert rst after 2 shifting edges -> busy, done, y and cout go to 0 immediately; no done after release; the next start completes normally.
